univ_shift_reg_n: RTL

//  Parametrised universal shift register with WIDTH-bit storage and eight modes:

---
 rtl/univ_shift_reg_n_pkg.sv | 32 +++
 rtl/univ_shift_reg_n_if.sv | 37 +++
 rtl/univ_shift_reg_n_step.sv | 42 ++++
 rtl/univ_shift_reg_n.sv | 102 ++++++++++
 4 files changed

// File: rtl/univ_shift_reg_n_pkg.sv
// ----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register: the operation-mode
// encodings, the FSM state type, and a helper that tells which modes may be
// repeated by the multi-step engine.
// ----------------------------------------------------------------------------
package usr_pkg;

    localparam logic [2:0] USR_HOLD = 3'b000;
    localparam logic [2:0] USR_SHL  = 3'b001;
    localparam logic [2:0] USR_SHR  = 3'b010;
    localparam logic [2:0] USR_LOAD = 3'b011;
    localparam logic [2:0] USR_ROTL = 3'b100;
    localparam logic [2:0] USR_ROTR = 3'b101;
    localparam logic [2:0] USR_ASHR = 3'b110;
    localparam logic [2:0] USR_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } usr_state_e;

    // Shift and rotate modes change the register on every repetition. Hold,
    // load and clear give the same result however often they are applied,
    // so they never enter RUN.
    function automatic logic usr_is_multi(input logic [2:0] mode);
        return (mode == USR_SHL)  || (mode == USR_SHR)  ||
               (mode == USR_ROTL) || (mode == USR_ROTR) ||
               (mode == USR_ASHR);
    endfunction

endpackage

// File: rtl/univ_shift_reg_n_if.sv
// ----------------------------------------------------------------------------
// univ_shift_reg_n_if
// Control/data bundle of the universal shift register.
//   master : drives en, mode, data_in, sin_left, sin_right, start, amt;
//            observes data_out, sout_left, sout_right, busy, done
//   slave  : the shift register itself (opposite directions)
// CNT_W is the width of amt and of the internal step counter.
// ----------------------------------------------------------------------------
interface univ_shift_reg_n_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] data_in;
    logic             sin_left;
    logic             sin_right;
    logic             start;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] data_out;
    logic             sout_left;
    logic             sout_right;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, data_in, sin_left, sin_right, start, amt,
        input  data_out, sout_left, sout_right, busy, done
    );

    modport slave (
        input  en, mode, data_in, sin_left, sin_right, start, amt,
        output data_out, sout_left, sout_right, busy, done
    );

endinterface

// File: rtl/univ_shift_reg_n_step.sv
// ----------------------------------------------------------------------------
// usr_step
// One step of the universal shift register, purely combinational. The
// single-step path and the RUN engine both use this block, so every
// operation is defined in exactly one place.
//   q         in   WIDTH  current register contents
//   mode      in   3      operation select
//   sin_left  in   1      bit entering bit 0 on shift-left
//   sin_right in   1      bit entering bit WIDTH-1 on logical shift-right
//   q_next    out  WIDTH  contents after one step
// ----------------------------------------------------------------------------
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sin_left,
    input  logic             sin_right,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        // NOTE: q_next gets a value before the case so no path through this
        // block leaves it unassigned, which would otherwise infer a latch.
        q_next = q;
        case (mode)
            USR_HOLD: q_next = q;
            USR_SHL:  q_next = {q[WIDTH-2:0], sin_left};
            USR_SHR:  q_next = {sin_right, q[WIDTH-1:1]};
            USR_LOAD: q_next = data_in;
            USR_ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            USR_ROTR: q_next = {q[0], q[WIDTH-1:1]};
            USR_ASHR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            USR_CLR:  q_next = '0;
            default:  q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_n.sv
// ----------------------------------------------------------------------------
// univ_shift_reg_n
// WIDTH-bit universal shift register with eight modes and a multi-step
// engine. A start pulse repeats one operation 'amt' times, doing one step
// per enabled cycle, and reports through busy/done.
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of univ_shift_reg_n_if:
//            en, mode, data_in, sin_left, sin_right, start, amt in;
//            data_out, sout_left, sout_right, busy, done out
// ----------------------------------------------------------------------------
module univ_shift_reg_n
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    univ_shift_reg_n_if.slave    bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    usr_state_e       state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] step_q;
    logic [2:0]       run_mode;
    logic [2:0]       step_mode;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;

    // While RUN is active the operation comes from the latched mode. Changes
    // on the live mode input therefore cannot disturb a sequence in flight.
    assign step_mode = (state == ST_RUN) ? run_mode : bus.mode;

    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q         (q),
        .mode      (step_mode),
        .data_in   (bus.data_in),
        .sin_left  (bus.sin_left),
        .sin_right (bus.sin_right),
        .q_next    (step_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            q        <= '0;
            run_mode <= USR_HOLD;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: all state updates here are non-blocking, so every
            // right-hand side reads the value from before this edge.
            done_q <= 1'b0;
            if (bus.en) begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            run_mode <= bus.mode;
                            cnt      <= bus.amt;
                            if ((bus.amt != '0) && usr_is_multi(bus.mode)) begin
                                state  <= ST_RUN;
                                busy_q <= 1'b1;
                            end else begin
                                // Load and clear still take effect when they
                                // are started. A zero count or hold leaves
                                // q as it is.
                                if ((bus.mode == USR_LOAD) || (bus.mode == USR_CLR))
                                    q <= step_q;
                                done_q <= 1'b1;
                            end
                        end else begin
                            q <= step_q;
                        end
                    end
                    ST_RUN: begin
                        q   <= step_q;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.data_out   = q;
    assign bus.sout_left  = q[WIDTH-1];
    assign bus.sout_right = q[0];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
